// File: rtl/fta_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fta_bus_pkg - FTA request/response types for 128-bit ports      |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package fta_bus_pkg;

    typedef enum logic [4:0] {
        CMD_NONE  = 5'd0,
        CMD_LOAD  = 5'd1,
        CMD_STORE = 5'd2
    } fta_cmd_t;

    typedef struct packed {
        logic [5:0] core;
        logic [2:0] channel;
        logic [7:0] tranid;
    } fta_tranid_t;

    typedef struct packed {
        logic          cyc;
        logic          stb;
        logic          we;
        logic [15:0]   sel;
        logic [31:0]   adr;
        logic [127:0]  dat;
        fta_cmd_t      cmd;
        fta_tranid_t   tid;
    } fta_cmd_request128_t;

    typedef struct packed {
        logic          ack;
        logic          rty;
        logic          err;
        fta_tranid_t   tid;
        logic [31:0]   adr;
        logic [127:0]  dat;
    } fta_cmd_response128_t;

endpackage
`default_nettype wire

// File: rtl/fta_scratchpad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fta_scratchpad_pkg - queue entry type for the scratchpad slave  |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package fta_scratchpad_pkg;
    import fta_bus_pkg::*;

    localparam int LINE_BYTES  = 16;
    // Wide enough for any window up to the full 32-bit space.
    localparam int QENT_LINE_W = 28;

    typedef struct packed {
        logic                      we;
        logic [LINE_BYTES-1:0]     sel;
        logic [QENT_LINE_W-1:0]    line;
        logic [8*LINE_BYTES-1:0]   dat;
        fta_tranid_t               tid;
        logic [31:0]               adr;
    } fta_sp_qent_t;

endpackage
`default_nettype wire

// File: rtl/fta_sp_req_fifo.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fta_sp_req_fifo - synchronous request FIFO, show-ahead output   |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module fta_sp_req_fifo
    import fta_scratchpad_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  fta_sp_qent_t             din,
    output fta_sp_qent_t             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    fta_sp_qent_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/fta_scratchpad_responder.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fta_scratchpad_responder - in-order FTA responder for scratchpad|
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module fta_scratchpad_responder
    import fta_bus_pkg::*;
    import fta_scratchpad_pkg::*;
#(
    parameter logic [31:0] BASE_ADR  = 32'hFFFF0000,
    parameter int          SIZE_LOG2 = 14,
    parameter int          QDEPTH    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  fta_cmd_request128_t  req_i,
    output fta_cmd_response128_t resp_o
);
    localparam int LINE_W = SIZE_LOG2 - 4;
    localparam int LINES  = 2 ** LINE_W;
    localparam int CNT_W  = $clog2(QDEPTH) + 1;

    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_fifo_full;
    logic             w_empty;
    logic             w_hold_busy;
    logic             w_m_adv;
    logic [CNT_W-1:0] w_q_count;
    logic [LINE_W-1:0] w_line;
    logic             w_unused;
    fta_sp_qent_t     w_ent;
    fta_sp_qent_t     w_head;

    logic             r_rty_v;
    fta_tranid_t      r_rty_tid;
    logic [31:0]      r_rty_adr;

    logic [127:0]     r_ram [LINES];
    logic [127:0]     r_rdata;

    logic             r_m_valid;
    logic             r_m_we;
    fta_tranid_t      r_m_tid;
    logic [31:0]      r_m_adr;

    logic             r_h_valid;
    fta_tranid_t      r_h_tid;
    logic [31:0]      r_h_adr;
    logic [127:0]     r_h_dat;

    assign w_valid = req_i.cyc & req_i.stb & (req_i.cmd != CMD_NONE)
                   & (req_i.adr[31:SIZE_LOG2] == BASE_ADR[31:SIZE_LOG2]);
    assign w_full  = w_fifo_full;
    assign w_push  = w_valid & ~w_full;

    always_comb begin
        w_ent      = '0;
        w_ent.we   = req_i.we;
        w_ent.sel  = req_i.sel;
        w_ent.line = QENT_LINE_W'(req_i.adr[SIZE_LOG2-1:4]);
        w_ent.dat  = req_i.dat;
        w_ent.tid  = req_i.tid;
        w_ent.adr  = req_i.adr;
    end

    fta_sp_req_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_ent),
        .dout  (w_head),
        .count (w_q_count),
        .empty (w_empty),
        .full  (w_fifo_full)
    );

    assign w_line   = w_head.line[LINE_W-1:0];
    assign w_unused = ^{w_head.line, w_q_count};

    // The holding register cannot drain while a retry owns the port;
    // everything behind it then freezes, including the queue head.
    assign w_hold_busy = r_h_valid & r_rty_v;
    assign w_m_adv     = ~r_m_valid | ~w_hold_busy;
    assign w_pop       = ~w_empty & w_m_adv;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rty_v <= 1'b0;
        end else begin
            r_rty_v <= w_valid & w_full;
        end
        if (w_valid & w_full) begin
            r_rty_tid <= req_i.tid;
            r_rty_adr <= req_i.adr;
        end
    end

    // Read data is only refreshed on a read pop, so it stays put while M stalls.
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_pop) begin
            if (w_head.we) begin
                for (int i = 0; i < LINE_BYTES; i++) begin
                    if (w_head.sel[i]) r_ram[w_line][i*8 +: 8] <= w_head.dat[i*8 +: 8];
                end
            end else begin
                r_rdata <= r_ram[w_line];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_m_valid <= 1'b0;
        end else if (w_m_adv) begin
            r_m_valid <= w_pop;
        end
        if (w_pop) begin
            r_m_we  <= w_head.we;
            r_m_tid <= w_head.tid;
            r_m_adr <= w_head.adr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_h_valid <= 1'b0;
        end else if (!w_hold_busy) begin
            r_h_valid <= r_m_valid;
        end
        if (r_m_valid && !w_hold_busy) begin
            r_h_tid <= r_m_tid;
            r_h_adr <= r_m_adr;
            r_h_dat <= r_m_we ? 128'h0 : r_rdata;
        end
    end

    always_comb begin
        resp_o = '0;
        if (r_rty_v) begin
            resp_o.rty = 1'b1;
            resp_o.tid = r_rty_tid;
            resp_o.adr = r_rty_adr;
        end else if (r_h_valid) begin
            resp_o.ack = 1'b1;
            resp_o.tid = r_h_tid;
            resp_o.adr = r_h_adr;
            resp_o.dat = r_h_dat;
        end
    end

endmodule
`default_nettype wire
